regfile_read_port: RTL and testbench

- Reader side of the register-file bitline interface.
- Accepts a pair of source-register addresses over a valid/ready handshake and drives one-hot rden1/rden2 strobes onto the register rows for exactly one cycle.
- Samples the shared bitline1/bitline2 buses and returns both operands over a valid/ready response handshake.
- Forwards a same-cycle register write so the decode stage never sees stale data.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_read_port_if.sv | 25 ++
 rtl/regfile_rd_decode.sv | 22 ++
 rtl/regfile_read_port.sv | 89 ++++++++
 tb/tb_regfile_read_port.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read port: default geometry and
// the read-port FSM state encoding.
package regfile_pkg;

    localparam int NREGS = 16;
    localparam int DW    = 16;
    localparam int AW    = 4;

    // 2'b11 is unused; the FSM folds it back to RP_IDLE.
    typedef enum logic [1:0] {
        RP_IDLE = 2'b00,
        RP_READ = 2'b01,
        RP_RESP = 2'b10
    } rp_state_e;

endpackage

// File: rtl/regfile_read_port_if.sv
// Request/response handshake between an issuing stage (master) and the
// register-file read port (slave).
interface regfile_read_port_if #(
    parameter int AW = regfile_pkg::AW,
    parameter int DW = regfile_pkg::DW
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] src_reg1;
    logic [AW-1:0] src_reg2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] src_data1;
    logic [DW-1:0] src_data2;

    modport master (
        output req_valid, src_reg1, src_reg2, rsp_ready,
        input  req_ready, rsp_valid, src_data1, src_data2
    );

    modport slave (
        input  req_valid, src_reg1, src_reg2, rsp_ready,
        output req_ready, rsp_valid, src_data1, src_data2
    );
endinterface

// File: rtl/regfile_rd_decode.sv
// Address-to-one-hot row select. With en low the vector is all-zero, so no
// row drives its bitline. Shared by both read ports and the write decoder.
module regfile_rd_decode #(
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // Compare every row index against the address; at most one bit matches.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned
        // and a latch is never inferred.
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Reader side of the register-file bitline interface. Latches an operand
// address pair, strobes the selected rows for one cycle, captures both
// bitlines (with same-cycle write forwarding) and returns the operands.
module regfile_read_port #(
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    regfile_read_port_if.slave bus,
    output logic [NREGS-1:0]  rden1,
    output logic [NREGS-1:0]  rden2,
    input  logic [DW-1:0]     bitline1,
    input  logic [DW-1:0]     bitline2,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_reg,
    input  logic [DW-1:0]     wr_data
);
    import regfile_pkg::*;

    rp_state_e     state;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic          accept;
    logic          in_read;

    // A new pair can enter while idle, or while the current response is
    // being consumed in the same cycle. Held low throughout reset.
    assign bus.req_ready = rst & ((state == RP_IDLE) |
                                  ((state == RP_RESP) & bus.rsp_ready));
    assign accept        = bus.req_valid & bus.req_ready;
    assign in_read       = (state == RP_READ);

    assign bus.rsp_valid = (state == RP_RESP);
    assign bus.src_data1 = data1;
    assign bus.src_data2 = data2;

    // Strobes are derived from the state register, so reset clears them
    // immediately without waiting for a clock edge.
    regfile_rd_decode #(.NREGS(NREGS), .AW(AW)) u_dec1 (
        .addr   (addr1),
        .en     (in_read),
        .onehot (rden1)
    );

    regfile_rd_decode #(.NREGS(NREGS), .AW(AW)) u_dec2 (
        .addr   (addr2),
        .en     (in_read),
        .onehot (rden2)
    );

    // Sequencer: IDLE -> READ (one cycle) -> RESP, with back-to-back reuse of RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RP_IDLE;
            addr1 <= '0;
            addr2 <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values, independent of statement order.
            if (accept) begin
                addr1 <= bus.src_reg1;
                addr2 <= bus.src_reg2;
            end
            case (state)
                RP_IDLE: if (accept) state <= RP_READ;
                RP_READ: state <= RP_RESP;
                RP_RESP: if (bus.rsp_ready) state <= accept ? RP_READ : RP_IDLE;
                default: state <= RP_IDLE;
            endcase
        end
    end

    // Operand capture at the end of READ. A row being written this cycle
    // still shows its old value on the bitline, so forward wr_data instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1 <= '0;
            data2 <= '0;
        end else if (in_read) begin
            data1 <= (wr_en && (wr_reg == addr1)) ? wr_data : bitline1;
            data2 <= (wr_en && (wr_reg == addr2)) ? wr_data : bitline2;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: a behavioural register array
// drives the bitlines, a scoreboard queue holds the expected operand pairs.
module tb_regfile_read_port;
    import regfile_pkg::*;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREGS-1:0] rden1;
    logic [NREGS-1:0] rden2;
    logic [DW-1:0]    bitline1;
    logic [DW-1:0]    bitline2;
    logic             wr_en;
    logic [AW-1:0]    wr_reg;
    logic [DW-1:0]    wr_data;

    logic [DW-1:0]    rows [NREGS];
    rsp_t             exp_q [$];
    rsp_t             got_e;
    int               checks = 0;
    int               errors = 0;

    regfile_read_port_if #(.AW(AW), .DW(DW)) bus ();

    regfile_read_port #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rden1    (rden1),
        .rden2    (rden2),
        .bitline1 (bitline1),
        .bitline2 (bitline2),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Register rows: written at the clock edge, read onto a wired-OR bitline.
    always @(posedge clk) if (wr_en) rows[wr_reg] <= wr_data;

    always_comb begin
        bitline1 = '0;
        bitline2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rden1[i]) bitline1 = bitline1 | rows[i];
            if (rden2[i]) bitline2 = bitline2 | rows[i];
        end
    end

    // Response monitor: every accepted response must match the next expectation.
    always @(negedge clk) begin
        if (rst && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_rsp: got %h/%h, expected no response",
                         bus.src_data1, bus.src_data2);
            end else begin
                got_e = exp_q.pop_front();
                if (bus.src_data1 !== got_e.d1 || bus.src_data2 !== got_e.d2) begin
                    errors++;
                    $display("FAIL rsp_data: got %h/%h, expected %h/%h",
                             bus.src_data1, bus.src_data2, got_e.d1, got_e.d2);
                end
            end
        end
    end

    function automatic rsp_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
        rsp_t r;
        r.d1 = a;
        r.d2 = b;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_reg = a; wr_data = d;
        next_cycle();
        wr_en = 1'b0;
    endtask

    // Present a pair from IDLE; returns one cycle later, inside READ.
    task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.req_valid = 1'b1; bus.src_reg1 = a1; bus.src_reg2 = a2;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b, expected 1", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || rden1 !== '0 || rden2 !== '0 ||
            bus.src_data1 !== '0 || bus.src_data2 !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b rden=%h/%h data=%h/%h, expected 0 0 0/0 0/0",
                     bus.req_ready, bus.rsp_valid, rden1, rden2, bus.src_data1, bus.src_data2);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, expected 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        write_reg(3, 16'hA5A5);
        write_reg(7, 16'h1234);
        bus.rsp_ready = 1'b1;
        exp_q.push_back(mk(16'hA5A5, 16'h1234));
        issue(3, 7);
        @(negedge clk);
        checks++;
        if (rden1 !== 16'h0008 || rden2 !== 16'h0080) begin
            errors++;
            $display("FAIL basic_rden: got %h/%h, expected 0008/0080", rden1, rden2);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.src_data1 !== 16'hA5A5 || bus.src_data2 !== 16'h1234) begin
            errors++;
            $display("FAIL basic_rsp: got v=%b %h/%h, expected v=1 a5a5/1234",
                     bus.rsp_valid, bus.src_data1, bus.src_data2);
        end
        next_cycle();
    endtask

    task automatic test_bypass();
        write_reg(5, 16'h0000);
        exp_q.push_back(mk(16'hBEEF, 16'hA5A5));
        issue(5, 3);
        wr_en = 1'b1; wr_reg = 5; wr_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (rden1 !== 16'h0020 || rden2 !== 16'h0008) begin
            errors++;
            $display("FAIL bypass_rden: got %h/%h, expected 0020/0008", rden1, rden2);
        end
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.src_data1 !== 16'hBEEF || bus.src_data2 !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_data: got %h/%h, expected beef/a5a5", bus.src_data1, bus.src_data2);
        end
        next_cycle();
    endtask

    task automatic test_same_reg();
        write_reg(9, 16'h00FF);
        exp_q.push_back(mk(16'h00FF, 16'h00FF));
        issue(9, 9);
        @(negedge clk);
        checks++;
        if (rden1 !== 16'h0200 || rden2 !== 16'h0200) begin
            errors++;
            $display("FAIL same_rden: got %h/%h, expected 0200/0200", rden1, rden2);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.src_data1 !== 16'h00FF || bus.src_data2 !== 16'h00FF) begin
            errors++;
            $display("FAIL same_data: got %h/%h, expected 00ff/00ff", bus.src_data1, bus.src_data2);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        write_reg(2, 16'h1111);
        write_reg(4, 16'h2222);
        bus.rsp_ready = 1'b0;
        exp_q.push_back(mk(16'h1111, 16'h2222));
        issue(2, 4);
        next_cycle();
        bus.req_valid = 1'b1; bus.src_reg1 = 2; bus.src_reg2 = 4;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                wr_en = 1'b1; wr_reg = 2; wr_data = 16'hDEAD;
            end
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.src_data1 !== 16'h1111 || bus.src_data2 !== 16'h2222 ||
                bus.req_ready !== 1'b0 || rden1 !== '0 || rden2 !== '0) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b %h/%h rdy=%b rden=%h/%h, expected v=1 1111/2222 rdy=0 rden=0/0",
                         i, bus.rsp_valid, bus.src_data1, bus.src_data2, bus.req_ready, rden1, rden2);
            end
            next_cycle();
            wr_en = 1'b0;
        end
        exp_q.push_back(mk(16'hDEAD, 16'h2222));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b, expected 1", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rden1 !== 16'h0004 || rden2 !== 16'h0010) begin
            errors++;
            $display("FAIL release_rden: got %h/%h, expected 0004/0010", rden1, rden2);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] pa [4];
        logic [AW-1:0] pb [4];
        int waits;
        pa = '{4'd3, 4'd9, 4'd2, 4'd7};
        pb = '{4'd7, 4'd5, 4'd4, 4'd3};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1; bus.src_reg1 = pa[k]; bus.src_reg2 = pb[k];
            exp_q.push_back(mk(rows[pa[k]], rows[pb[k]]));
            waits = 0;
            for (int t = 0; t < 8; t++) begin
                @(negedge clk);
                if (bus.req_ready) break;
                waits++;
            end
            checks++;
            if (waits != ((k == 0) ? 0 : 1)) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: waited %0d cycles, expected %0d",
                         k, waits, (k == 0) ? 0 : 1);
            end
            next_cycle();
        end
        bus.req_valid = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        bus.rsp_ready = 1'b1;
        issue(3, 7);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rden1 !== '0 || rden2 !== '0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got rden=%h/%h v=%b rdy=%b, expected 0/0 0 0",
                     rden1, rden2, bus.rsp_valid, bus.req_ready);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.src_data1 !== '0 || bus.src_data2 !== '0) begin
            errors++;
            $display("FAIL midreset_release: got rdy=%b data=%h/%h, expected 1 0000/0000",
                     bus.req_ready, bus.src_data1, bus.src_data2);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_norsp_%0d: got valid=%b, expected 0", i, bus.rsp_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; wr_reg = '0; wr_data = '0;
        bus.req_valid = 1'b0; bus.src_reg1 = '0; bus.src_reg2 = '0; bus.rsp_ready = 1'b0;

        test_reset();
        test_basic();
        test_bypass();
        test_same_reg();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
